// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: operation encodings
// and small helpers that classify an operation.
package shift_pkg;

  // Operation select, sampled only on a divider tick.
  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLR   = 3'b110,
    MODE_HOLD2 = 3'b111
  } mode_e;

  // Shift and rotate operations move one bit out and advance the shift count.
  function automatic logic is_shift_mode(input mode_e m);
    return (m == MODE_SHL) || (m == MODE_SHR) ||
           (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

  // Load and clear restart the shift count from zero.
  function automatic logic is_count_reset_mode(input mode_e m);
    return (m == MODE_LOAD) || (m == MODE_CLR);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock-enable divider: counts 0..DIV-1 on clk_50M and raises tick for the
// single cycle in which the count sits at its terminal value. restart zeroes
// the count on the next edge and suppresses the tick of the cycle it is high.
module tick_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic clk_50M,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          at_term;

  assign at_term = (cnt == TERM);

  // Divider counter: wraps at the terminal count, restart forces it to zero.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || at_term) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Reset is included so that DIV = 1 (counter always at terminal) still
  // shows tick low while reset is held.
  assign tick = at_term && !restart && !reset;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register clocked by clk_50M and enabled once per DIV
// cycles by tick_gen. On a tick the selected operation updates the register,
// the shifted-out bit (sout) and a saturating shift counter that drives full.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 50_000_000
) (
  input  logic             clk_50M,
  input  logic             reset,
  input  logic             in,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             restart,
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic             tick,
  output logic             full
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam logic [SW-1:0] SMAX = SW'(WIDTH);

  mode_e            mode_sel;
  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_d;
  logic             sout_q;
  logic             sout_d;
  logic [SW-1:0]    scnt_q;
  logic [SW-1:0]    scnt_d;

  assign mode_sel = mode_e'(mode);

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk_50M (clk_50M),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  // Next-state for register, departing bit and shift count; off-tick cycles
  // hold everything, so input changes between ticks have no effect.
  always_comb begin
    reg_d  = reg_q;
    sout_d = sout_q;
    scnt_d = scnt_q;
    if (tick) begin
      case (mode_sel)
        MODE_SHL: begin
          reg_d  = {reg_q[WIDTH-2:0], in};
          sout_d = reg_q[WIDTH-1];
        end
        MODE_SHR: begin
          reg_d  = {in, reg_q[WIDTH-1:1]};
          sout_d = reg_q[0];
        end
        MODE_ROL: begin
          reg_d  = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
          sout_d = reg_q[WIDTH-1];
        end
        MODE_ROR: begin
          reg_d  = {reg_q[0], reg_q[WIDTH-1:1]};
          sout_d = reg_q[0];
        end
        MODE_LOAD: reg_d = din;
        MODE_CLR:  reg_d = '0;
        default:   reg_d = reg_q;
      endcase
      if (is_count_reset_mode(mode_sel)) begin
        scnt_d = '0;
      end else if (is_shift_mode(mode_sel) && (scnt_q != SMAX)) begin
        scnt_d = scnt_q + SW'(1);
      end
    end
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      reg_q  <= '0;
      sout_q <= 1'b0;
      scnt_q <= '0;
    end else begin
      reg_q  <= reg_d;
      sout_q <= sout_d;
      scnt_q <= scnt_d;
    end
  end

  assign out  = reg_q;
  assign sout = sout_q;
  assign full = (scnt_q == SMAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg with WIDTH = 8, DIV = 4. Inputs change
// and outputs are sampled on the falling edge of clk_50M.
module tb_univ_shift_reg;
  import shift_pkg::*;

  localparam int WIDTH = 8;
  localparam int DIV   = 4;

  logic             clk_50M = 1'b0;
  logic             reset;
  logic             in;
  logic [2:0]       mode;
  logic [WIDTH-1:0] din;
  logic             restart;
  logic [WIDTH-1:0] out;
  logic             sout;
  logic             tick;
  logic             full;

  int checks = 0;
  int errors = 0;
  int n;

  univ_shift_reg #(
    .WIDTH(WIDTH),
    .DIV  (DIV)
  ) dut (
    .clk_50M (clk_50M),
    .reset   (reset),
    .in      (in),
    .mode    (mode),
    .din     (din),
    .restart (restart),
    .out     (out),
    .sout    (sout),
    .tick    (tick),
    .full    (full)
  );

  // clock
  always #5 clk_50M = ~clk_50M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // From a falling edge, advance falling edges until tick is seen high.
  // n returns how many edges were advanced.
  task automatic wait_tick(output int cnt);
    cnt = 0;
    while (tick !== 1'b1 && cnt < 20) begin
      @(negedge clk_50M);
      cnt++;
    end
    if (tick !== 1'b1) check("tick_timeout", 32'(tick), 1);
  endtask

  // Present one operation, let it execute on the next tick, then return to hold.
  task automatic do_op(input logic [2:0] m, input logic [WIDTH-1:0] d, input logic s);
    int k;
    mode = m;
    din  = d;
    in   = s;
    wait_tick(k);
    @(negedge clk_50M);
    mode = MODE_HOLD;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    in      = 1'b0;
    mode    = MODE_HOLD;
    din     = '0;
    restart = 1'b0;
    repeat (3) @(negedge clk_50M);

    // Reset state
    check("rst_out",  32'(out),  'h00);
    check("rst_sout", 32'(sout), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_full", 32'(full), 0);

    // Tick cadence under hold
    reset = 1'b0;
    wait_tick(n);
    check("first_tick_edges", 32'(n), 3);
    @(negedge clk_50M);
    check("tick_one_cycle", 32'(tick), 0);
    check("hold_out", 32'(out), 'h00);
    check("hold_full", 32'(full), 0);
    wait_tick(n);
    check("tick_period", 32'(n + 1), 4);
    @(negedge clk_50M);

    // Load then three rotate-left ticks
    do_op(MODE_LOAD, 8'hA5, 1'b0);
    check("load_a5", 32'(out), 'hA5);
    check("load_a5_full", 32'(full), 0);
    do_op(MODE_ROL, 8'h00, 1'b0);
    check("rol1_out", 32'(out), 'h4B);
    check("rol1_sout", 32'(sout), 1);
    do_op(MODE_ROL, 8'h00, 1'b0);
    check("rol2_out", 32'(out), 'h96);
    check("rol2_sout", 32'(sout), 0);
    do_op(MODE_ROL, 8'h00, 1'b0);
    check("rol3_out", 32'(out), 'h2D);
    check("rol3_sout", 32'(sout), 1);
    check("rol3_full", 32'(full), 0);

    // Inputs changed between ticks must not act
    mode = MODE_CLR;
    din  = 8'hFF;
    in   = 1'b1;
    repeat (2) @(negedge clk_50M);
    check("between_ticks_out", 32'(out), 'h2D);
    mode = MODE_HOLD;
    wait_tick(n);
    @(negedge clk_50M);
    check("after_hold_out", 32'(out), 'h2D);

    // Fill with ones, full after the 8th shift and saturated on the 9th
    do_op(MODE_LOAD, 8'h00, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      do_op(MODE_SHL, 8'h00, 1'b1);
      if (i == 7) begin
        check("shl7_out", 32'(out), 'h7F);
        check("shl7_full", 32'(full), 0);
      end
    end
    check("shl8_out", 32'(out), 'hFF);
    check("shl8_full", 32'(full), 1);
    check("shl8_sout", 32'(sout), 0);
    do_op(MODE_SHL, 8'h00, 1'b1);
    check("shl9_out", 32'(out), 'hFF);
    check("shl9_full", 32'(full), 1);
    check("shl9_sout", 32'(sout), 1);

    // Shift right then clear
    do_op(MODE_LOAD, 8'h81, 1'b0);
    check("load81_out", 32'(out), 'h81);
    check("load81_full", 32'(full), 0);
    do_op(MODE_SHR, 8'h00, 1'b0);
    check("shr_out", 32'(out), 'h40);
    check("shr_sout", 32'(sout), 1);
    do_op(MODE_CLR, 8'h00, 1'b0);
    check("clr_out", 32'(out), 'h00);
    check("clr_full", 32'(full), 0);
    check("clr_sout", 32'(sout), 1);

    // Restart on the terminal-count cycle
    do_op(MODE_LOAD, 8'h55, 1'b0);
    mode = MODE_ROL;
    wait_tick(n);
    restart = 1'b1;
    #1;
    check("restart_tick_suppressed", 32'(tick), 0);
    @(negedge clk_50M);
    restart = 1'b0;
    mode    = MODE_HOLD;
    check("restart_out", 32'(out), 'h55);
    wait_tick(n);
    check("restart_gap", 32'(n + 1), 4);
    @(negedge clk_50M);
    check("restart_out_after", 32'(out), 'h55);

    // Reset mid-count
    do_op(MODE_LOAD, 8'h3C, 1'b0);
    check("load3c_out", 32'(out), 'h3C);
    @(negedge clk_50M);
    reset = 1'b1;
    #1;
    check("midrst_out", 32'(out), 'h00);
    check("midrst_sout", 32'(sout), 0);
    check("midrst_tick", 32'(tick), 0);
    check("midrst_full", 32'(full), 0);
    repeat (2) @(negedge clk_50M);
    reset = 1'b0;
    wait_tick(n);
    check("midrst_first_tick_edges", 32'(n), 3);
    @(negedge clk_50M);
    check("midrst_out_after", 32'(out), 'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (WIDTH >= 2).
REQ-002 Parameter DIV, default 50_000_000, clk_50M cycles per shift tick (DIV >= 1).
REQ-003 clk_50M  input  1  system clock, the only clock; all flops on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in  input  1  serial data in.
REQ-006 mode  input  3  operation select, sampled on tick.
REQ-007 din  input  WIDTH  parallel load data.
REQ-008 restart  input  1  synchronous divider restart.
REQ-009 out  output  WIDTH  register contents.
REQ-010 sout  output  1  last bit shifted or rotated out.
REQ-011 tick  output  1  one-cycle pulse marking the cycle an operation executes.
REQ-012 full  output  1  WIDTH shift/rotate operations completed since the last load/clear.

Function
REQ-013 Divider counter SHALL count 0..DIV-1 and wrap; tick = 1 when counter == DIV-1; DIV = 1 gives tick every cycle.
REQ-014 Register SHALL update only on clk_50M edges where tick = 1; no derived clock.
REQ-015 mode on tick: 000 hold; 001 shift left, in -> bit 0; 010 shift right, in -> bit WIDTH-1; 011 rotate left; 100 rotate right; 101 load din; 110 clear to 0; 111 hold.
REQ-016 sout SHALL take the departing bit: bit WIDTH-1 for 001/011, bit 0 for 010/100; unchanged for other modes.
REQ-017 Shift counter SHALL increment on each 001-100 tick, saturate at WIDTH, and drive full = 1 when equal to WIDTH.
REQ-018 Modes 101 and 110 SHALL zero the shift counter and full in the same tick.
REQ-019 restart = 1 SHALL zero the divider counter next cycle and suppress tick that cycle; restart wins over a coincident terminal count.
REQ-020 mode/din/in changes between ticks SHALL have no effect until the next tick.
REQ-021 Latency: out, sout, full valid the cycle after the tick edge.

Reset
REQ-022 reset = 1 SHALL immediately force out = 0, sout = 0, tick = 0, full = 0, divider and shift counters = 0, irrespective of clock.
REQ-023 Reset asserted mid-count SHALL abandon the pending tick; after release, first tick occurs DIV cycles later.

Structure
REQ-024 Mode encodings (MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_LOAD, MODE_CLR) SHALL live in shared package shift_pkg.
REQ-025 Divider SHALL be sub-module tick_gen (params DIV; ports clk_50M, reset, restart, tick); counter width $clog2(DIV), min 1.
REQ-026 univ_shift_reg SHALL instantiate tick_gen and contain the register, sout and shift-counter logic.

Verification (WIDTH = 8, DIV = 4)
REQ-027 Release reset, mode = 000 -> tick every 4th cycle, out = 00h, full = 0.
REQ-028 Load din = A5h, then 3 ticks of 011 -> out = 2Dh, sout = 1, full = 0.
REQ-029 Load 00h, 8 ticks of 001 with in = 1 -> out = FFh, full = 1 after 8th tick, stays 1 on 9th.
REQ-030 Load 81h, one tick of 010 with in = 0 -> out = 40h, sout = 1; then 110 -> out = 00h, full = 0, sout still 1.
REQ-031 restart asserted on terminal-count cycle -> no tick that cycle, next tick 4 cycles later, out unchanged.
REQ-032 reset pulsed mid-count after loading 3Ch -> out = 00h immediately; first tick 4 cycles after release.
